// File: rtl/spike_fifo_arbiter_if.sv
// rtl/spike_fifo_arbiter_if.sv - requester and FIFO write-port bundle for spike_fifo_arbiter
interface spike_fifo_arbiter_if #(
  parameter int num_req   = 4,
  parameter int id_w      = 2,
  parameter int payload_w = 6
);
  logic [num_req-1:0]           req_valid;
  logic [num_req*payload_w-1:0] req_payload;
  logic [num_req-1:0]           req_ready;
  logic                         fifo_push_req_n;
  logic [id_w+payload_w-1:0]    fifo_data_in;
  logic                         fifo_full;

  modport master (
    output req_valid, req_payload, fifo_full,
    input  req_ready, fifo_push_req_n, fifo_data_in
  );

  modport slave (
    input  req_valid, req_payload, fifo_full,
    output req_ready, fifo_push_req_n, fifo_data_in
  );
endinterface

// File: rtl/spike_fifo_arbiter.sv
// rtl/spike_fifo_arbiter.sv - round-robin share of one spike FIFO among num_req requesters
// One-entry output stage tagged {id, payload}; saturating stall counter for congestion.
module spike_fifo_arbiter #(
  parameter int num_req   = 4,
  parameter int id_w      = 2,
  parameter int payload_w = 6,
  parameter int cnt_w     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_stall_clr,
  output logic [cnt_w-1:0] o_stall_count,
  spike_fifo_arbiter_if.slave bus
);

  logic                      r_stage_valid;
  logic [id_w+payload_w-1:0] r_stage_data;
  logic [id_w-1:0]           r_rr_ptr;
  logic [cnt_w-1:0]          r_stall_count;

  logic                      w_can_accept;
  logic                      w_found;
  logic [id_w-1:0]           w_grant_idx;
  logic [num_req-1:0]        w_grant;
  logic [payload_w-1:0]      w_payload;
  logic [id_w:0]             w_sum;
  logic [id_w-1:0]           w_cand;
  logic                      w_stalled;

  assign w_can_accept = !r_stage_valid || !bus.fifo_full;
  assign w_stalled    = r_stage_valid && bus.fifo_full;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    w_sum       = '0;
    w_cand      = '0;
    if (!rst && i_enable && w_can_accept) begin
      for (int k = 0; k < num_req; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (id_w+1)'(k);
        if (w_sum >= (id_w+1)'(num_req)) begin
          w_sum = w_sum - (id_w+1)'(num_req);
        end
        w_cand = w_sum[id_w-1:0];
        if (!w_found && bus.req_valid[w_cand]) begin
          w_found        = 1'b1;
          w_grant_idx    = w_cand;
          w_grant[w_cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_payload = '0;
    for (int k = 0; k < num_req; k++) begin
      if (w_grant[k]) begin
        w_payload = bus.req_payload[k*payload_w +: payload_w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_rr_ptr      <= '0;
      r_stall_count <= '0;
    end else begin
      // A grant reloads the stage even while it drains, sustaining one push per cycle.
      if (w_found) begin
        r_stage_data  <= {w_grant_idx, w_payload};
        r_stage_valid <= 1'b1;
        r_rr_ptr      <= (w_grant_idx == id_w'(num_req-1)) ? '0 : w_grant_idx + id_w'(1);
      end else if (r_stage_valid && !bus.fifo_full) begin
        r_stage_valid <= 1'b0;
      end

      if (i_stall_clr) begin
        r_stall_count <= '0;
      end else if (w_stalled && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + cnt_w'(1);
      end
    end
  end

  assign bus.req_ready       = w_grant;
  // Push is masked during reset so a staged entry being discarded is never written.
  assign bus.fifo_push_req_n = !(r_stage_valid && !rst);
  assign bus.fifo_data_in    = r_stage_data;
  assign o_stall_count       = r_stall_count;

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// tb/tb_spike_fifo_arbiter.sv - scoreboard bench for spike_fifo_arbiter
module tb_spike_fifo_arbiter;
  localparam int N  = 4;
  localparam int IDW = 2;
  localparam int PW = 6;
  localparam int CW = 4;
  localparam int DW = IDW + PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          stall_clr;
  logic [CW-1:0] stall_count;

  spike_fifo_arbiter_if #(.num_req(N), .id_w(IDW), .payload_w(PW)) bus ();

  spike_fifo_arbiter #(.num_req(N), .id_w(IDW), .payload_w(PW), .cnt_w(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .i_stall_clr   (stall_clr),
    .o_stall_count (stall_count),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] wr_log[$];

  int     m_ptr = 0;
  bit     m_sv = 0;
  int     m_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observes every accepted FIFO write and matches it against the scoreboard.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.fifo_push_req_n === 1'b0 && bus.fifo_full === 1'b0) begin
        wr_log.push_back(bus.fifo_data_in);
        if (sb_q.size() == 0) begin
          chk("unexpected_write", {24'd0, bus.fifo_data_in}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("write_data", {24'd0, bus.fifo_data_in}, {24'd0, e});
        end
      end
    end
  end

  task automatic cycle(input logic [N-1:0] v, input logic [N*PW-1:0] pay,
                       input bit full, input bit en, input bit clr, input bit r);
    int g;
    int idx;
    bit can;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    bus.req_valid   = v;
    bus.req_payload = pay;
    bus.fifo_full   = full;
    enable          = en;
    stall_clr       = clr;
    rst             = r;
    #1;
    g = -1;
    can = !m_sv || !full;
    if (!r && en && can) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_ready});
    chk("stall_count", {28'd0, stall_count}, m_stall);
    chk("push_req_n", {31'd0, bus.fifo_push_req_n}, {31'd0, !(m_sv && !r)});

    if (r) begin
      if (m_sv) void'(sb_q.pop_back());
      m_sv = 0;
      m_ptr = 0;
      m_stall = 0;
    end else begin
      if (clr) m_stall = 0;
      else if (m_sv && full && m_stall < (1 << CW) - 1) m_stall++;
      if (g >= 0) begin
        sb_q.push_back({g[IDW-1:0], pay[g*PW +: PW]});
        m_sv = 1;
        m_ptr = (g == N - 1) ? 0 : g + 1;
      end else if (m_sv && !full) begin
        m_sv = 0;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 0, 1, 0, 0);
  endtask

  localparam logic [N*PW-1:0] PAY1234 = {6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [N*PW-1:0] PAY15   = {6'h15, 6'h15, 6'h15, 6'h15};
  localparam logic [N*PW-1:0] PAY02   = {6'h02, 6'h02, 6'h02, 6'h02};
  logic [DW-1:0] exp_seq[7] = '{8'h01, 8'h42, 8'h83, 8'hC4, 8'h01, 8'h42, 8'h83};

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    stall_clr = 1'b0;
    bus.req_valid = '0;
    bus.req_payload = '0;
    bus.fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_push_n", {31'd0, bus.fifo_push_req_n}, 32'd1);
    chk("reset_data", {24'd0, bus.fifo_data_in}, 32'd0);
    chk("reset_stall", {28'd0, stall_count}, 32'd0);
    chk("reset_ready", {28'd0, bus.req_ready}, 32'd0);

    wr_log.delete();
    for (int i = 0; i < 8; i++) cycle(4'hF, PAY1234, 0, 1, 0, 0);
    settle();
    chk("rr_write_count", wr_log.size(), 7);
    for (int i = 0; i < 7 && i < wr_log.size(); i++) chk("rr_order", {24'd0, wr_log[i]}, {24'd0, exp_seq[i]});
    idle(2);

    cycle('0, '0, 0, 1, 0, 1);
    wr_log.delete();
    cycle(4'b0100, PAY15, 0, 1, 0, 0);
    cycle(4'b0010, PAY15, 0, 1, 0, 0);
    idle(1);
    settle();
    chk("single_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("single_req2", {24'd0, wr_log[0]}, 32'h95);
      chk("single_req1", {24'd0, wr_log[1]}, 32'h55);
    end

    cycle('0, '0, 0, 1, 0, 1);
    wr_log.delete();
    cycle(4'b0010, PAY02, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, PAY1234, 1, 1, 0, 0);
      chk("full_data_stable", {24'd0, bus.fifo_data_in}, 32'h42);
    end
    settle();
    chk("full_stall5", {28'd0, stall_count}, 32'd5);
    chk("full_no_write", wr_log.size(), 0);
    cycle('0, '0, 0, 1, 0, 0);
    idle(2);
    settle();
    chk("full_one_write", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("full_write_val", {24'd0, wr_log[0]}, 32'h42);

    cycle(4'b0001, PAY1234, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle('0, '0, 1, 1, 0, 0);
    settle();
    chk("stall_sat", {28'd0, stall_count}, 32'd15);
    cycle('0, '0, 1, 1, 1, 0);
    settle();
    chk("stall_clr", {28'd0, stall_count}, 32'd0);
    cycle('0, '0, 1, 1, 0, 0);
    settle();
    chk("stall_resume", {28'd0, stall_count}, 32'd1);
    idle(2);

    wr_log.delete();
    cycle(4'hF, PAY1234, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(4'hF, PAY1234, 0, 0, 0, 0);
    settle();
    chk("en_low_push_n", {31'd0, bus.fifo_push_req_n}, 32'd1);
    chk("en_low_writes", wr_log.size(), 1);

    wr_log.delete();
    cycle(4'hF, PAY1234, 0, 1, 0, 0);
    cycle(4'hF, PAY1234, 0, 1, 0, 1);
    settle();
    chk("rst_discard_push_n", {31'd0, bus.fifo_push_req_n}, 32'd1);
    chk("rst_discard_writes", wr_log.size(), 0);
    cycle(4'hF, PAY1234, 0, 1, 0, 0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), (N*PW)'({$urandom, $urandom}),
            ($urandom_range(2) == 0), ($urandom_range(7) != 0),
            ($urandom_range(15) == 0), ($urandom_range(63) == 0));
    end
    idle(4);
    settle();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spike_fifo_arbiter.md
Name: spike_fifo_arbiter

Overview:
- Round-robin arbiter that shares one spike event FIFO between num_req neuron requesters.
- Each accepted request is tagged with its requester ID and loaded into a one-entry output stage.
- The output stage drives the FIFO write port: active-low push request, data bus, full flag.
- Sits between the neuron update array and the spike FIFO. Provides backpressure and a stall counter for congestion monitoring.

Parameters:
- num_req, 4: number of requesters.
- id_w, 2: requester ID width. Must satisfy 2**id_w >= num_req.
- payload_w, 6: per-requester payload width. FIFO width = id_w + payload_w.
- cnt_w, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  arbitration enable. When low, no new grants are issued.
- req_valid  in  num_req  per-requester valid.
- req_payload  in  num_req*payload_w  packed payloads. Requester i occupies bits [i*payload_w +: payload_w].
- req_ready  out  num_req  per-requester grant/ready (one-hot or zero).
- fifo_push_req_n  out  1  FIFO push request, active-low.
- fifo_data_in  out  id_w+payload_w  FIFO write data, {id, payload}.
- fifo_full  in  1  FIFO full flag.
- stall_clr  in  1  synchronous clear of stall_count.
- stall_count  out  cnt_w  saturating count of cycles with staged data blocked by full.

Behaviour:
- Single clock, synchronous active-high rst. All state updates on posedge clk.
- Reset values:
  - stage_valid=0, so fifo_push_req_n=1.
  - fifo_data_in=0.
  - rr_ptr=0.
  - stall_count=0.
  - req_ready=0 whenever rst is high.
- Reset mid-operation discards any staged entry. Nothing is pushed in the reset cycle.
- can_accept = !stage_valid || !fifo_full. The stage is empty, or it drains this cycle.
- Grant (combinational):
  - If enable && can_accept, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping at num_req-1 back to 0.
  - req_ready = one-hot of that i, else 0.
  - req_ready never depends on req_valid of the same requester being low. A requester with req_valid=0 never gets ready.
- Transfer: req_valid[i] && req_ready[i]. On transfer:
  - stage_data <= {i[id_w-1:0], payload_i}; stage_valid <= 1.
  - rr_ptr <= (i == num_req-1) ? 0 : i+1.
  - rr_ptr is unchanged when no transfer occurs.
- Drain:
  - fifo_push_req_n = !stage_valid; fifo_data_in = stage_data.
  - The FIFO writes at the edge where push is low and fifo_full is low.
  - If drain occurs with no transfer in the same cycle, stage_valid <= 0.
  - Drain and transfer in the same cycle: the stage reloads back-to-back, giving 1 push per cycle sustained.
- Latency: transfer in cycle t → push asserted in cycle t+1 → written at end of t+1 if not full.
- Full:
  - While stage_valid && fifo_full, the stage holds. push_req_n stays low and data stays stable; the FIFO ignores the push.
  - req_ready is all 0 during this condition.
  - No data is lost or duplicated.
- Enable low: no grants, and the staged entry still drains normally.
- stall_count:
  - +1 per cycle with stage_valid && fifo_full. Saturates at all-ones, never wraps.
  - stall_clr has priority over increment: the counter goes to 0 that cycle.
- Fairness: with all requesters continuously valid and no full, the grant order is 0,1,2,3,0,… Each requester waits at most num_req-1 transfers.

Test Plan:
- Reset, then all 4 requesters valid with payloads 0x01..0x04, FIFO never full. Expected: FIFO receives 0x01,0x42,0x83,0xC4,0x01,… one per cycle, with the first push the cycle after the first grant.
- Only requester 2 valid, payload 0x15. Expected: push data 0x95. rr_ptr becomes 3; then requester 1 valid alone is granted immediately.
- fifo_full held high for 5 cycles with stage loaded at 0x42. Expected: push_req_n low and data 0x42 stable for all 5 cycles, req_ready=0, stall_count=5. After full drops, exactly one 0x42 is written.
- stall_count saturation with cnt_w=4: hold full for 20 cycles. Expected: count=15. Assert stall_clr while still full: count=0 the next cycle, then resumes counting.
- enable dropped with stage loaded and requests pending. Expected: staged entry pushed, no further req_ready, push_req_n=1 afterward.
- rst asserted the cycle after a grant. Expected: staged entry discarded, push_req_n=1, rr_ptr=0, no FIFO write.
